// File: rtl/counter_pkg.sv
// Shared types and default sizes for the seek controller and its counter.
package counter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DIV_W_DEF = 4;

    // CLEAR is a one-cycle state: not busy, but not accepting commands either.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/counter_seek_ctrl_if.sv
// Command and status bundle between a host command source and counter_seek_ctrl.
interface counter_seek_ctrl_if
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
);

    logic             CMD_VALID;
    logic             CMD_READY;
    logic             CMD_CLEAR;
    logic [WIDTH-1:0] CMD_TARGET;
    logic [DIV_W-1:0] CMD_RATE;
    logic             ABORT;
    logic [WIDTH-1:0] OUT;
    logic             BUSY;
    logic             DIR;
    logic             DONE;
    logic             ABORTED;

    modport master (
        output CMD_VALID, CMD_CLEAR, CMD_TARGET, CMD_RATE, ABORT,
        input  CMD_READY, OUT, BUSY, DIR, DONE, ABORTED
    );

    modport slave (
        input  CMD_VALID, CMD_CLEAR, CMD_TARGET, CMD_RATE, ABORT,
        output CMD_READY, OUT, BUSY, DIR, DONE, ABORTED
    );

endinterface

// File: rtl/updown_counter.sv
// Plain up/down counter with synchronous clear; clear wins over enable.
module updown_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             CLR,
    output logic [WIDTH-1:0] OUT
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = UP ? (cnt_q + ONE) : (cnt_q - ONE);
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign OUT = cnt_q;

endmodule

// File: rtl/counter_seek_ctrl.sv
// Steps an owned counter toward a commanded target at a programmable rate,
// with clear, abort and one-cycle completion pulses.
//   state | meaning
//   IDLE  | ready for a command, counter held
//   SEEK  | stepping toward target_q every rate_q+1 cycles
//   CLEAR | zeroing the counter, back to IDLE next edge
module counter_seek_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic                CLOCK,
    input  logic                RESET,
    counter_seek_ctrl_if.slave  bus
);

    localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_e           state_q,  state_d;
    logic [DIV_W-1:0] presc_q,  presc_d;
    logic [DIV_W-1:0] rate_q,   rate_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             dir_q,    dir_d;
    logic             done_q,   done_d;
    logic             abort_q,  abort_d;

    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             cnt_clr;
    logic             at_target;
    logic             step_due;

    assign at_target = (count == target_q);
    assign step_due  = (presc_q == rate_q);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        rate_d   = rate_q;
        target_d = target_q;
        dir_d    = dir_q;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        cnt_en   = 1'b0;
        cnt_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.CMD_VALID) begin
                    rate_d  = bus.CMD_RATE;
                    presc_d = '0;
                    if (bus.CMD_CLEAR) begin
                        target_d = '0;
                        dir_d    = 1'b0;
                        state_d  = ST_CLEAR;
                    end else begin
                        target_d = bus.CMD_TARGET;
                        dir_d    = (bus.CMD_TARGET > count);
                        state_d  = ST_SEEK;
                    end
                end
            end

            // Equality outranks ABORT so a seek that lands never reports aborted.
            ST_SEEK: begin
                if (at_target) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else if (step_due) begin
                    cnt_en  = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end

            ST_CLEAR: begin
                cnt_clr = 1'b1;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            rate_q   <= '0;
            target_q <= '0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            rate_q   <= rate_d;
            target_q <= target_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
        end
    end

    // Direction is fixed at accept; the seek is monotonic so it never flips mid-run.
    updown_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .EN    (cnt_en),
        .UP    (dir_q),
        .CLR   (cnt_clr),
        .OUT   (count)
    );

    assign bus.CMD_READY = (state_q == ST_IDLE);
    assign bus.BUSY      = (state_q == ST_SEEK);
    assign bus.OUT       = count;
    assign bus.DIR       = dir_q;
    assign bus.DONE      = done_q;
    assign bus.ABORTED   = abort_q;

endmodule

// File: tb/tb_counter_seek_ctrl.sv
// Directed bench for counter_seek_ctrl: per-cycle vector table plus seek, abort and reset sequences.
module tb_counter_seek_ctrl;

    logic CLOCK = 1'b0;
    logic RESET;

    counter_seek_ctrl_if #(.WIDTH(8), .DIV_W(4)) bus ();

    counter_seek_ctrl #(.WIDTH(8), .DIV_W(4)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic       valid;
        logic       clr;
        logic [7:0] tgt;
        logic [3:0] rate;
        logic       abort;
        logic [7:0] e_out;
        logic       e_rdy;
        logic       e_busy;
        logic       e_dir;
        logic       e_done;
        logic       e_abt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_cnt;

    function automatic vec_t v(input logic valid, input logic clr, input logic [7:0] tgt,
                               input logic [3:0] rate, input logic abort,
                               input logic [7:0] e_out, input logic e_rdy, input logic e_busy,
                               input logic e_dir, input logic e_done, input logic e_abt);
        vec_t r;
        r.valid = valid; r.clr = clr; r.tgt = tgt; r.rate = rate; r.abort = abort;
        r.e_out = e_out; r.e_rdy = e_rdy; r.e_busy = e_busy; r.e_dir = e_dir;
        r.e_done = e_done; r.e_abt = e_abt;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic valid, input logic clr, input logic [7:0] tgt,
                         input logic [3:0] rate, input logic abort);
        bus.CMD_VALID  = valid;
        bus.CMD_CLEAR  = clr;
        bus.CMD_TARGET = tgt;
        bus.CMD_RATE   = rate;
        bus.ABORT      = abort;
    endtask

    // Model: after accept at edge k, step n lands at edge k+n*(rate+1); DONE one edge after the last step.
    task automatic seek(input logic [7:0] tgt, input logic [3:0] rt);
        int         d;
        int         per;
        int         total;
        int         steps;
        int         eo;
        logic       up;
        logic       edone;
        up    = (32'(tgt) > exp_cnt);
        d     = up ? (32'(tgt) - exp_cnt) : (exp_cnt - 32'(tgt));
        per   = 32'(rt) + 1;
        total = d * per + 1;
        drive(1'b1, 1'b0, tgt, rt, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        chk($sformatf("seek%0d accept busy/dir/rdy", tgt),
            32'({bus.BUSY, bus.DIR, bus.CMD_READY}), 32'({1'b1, up, 1'b0}));
        for (int c = 1; c <= total; c++) begin
            tick();
            steps = c / per;
            if (steps > d) steps = d;
            eo    = up ? (exp_cnt + steps) : (exp_cnt - steps);
            edone = (c == total);
            chk($sformatf("seek%0d c%0d out/done/abt/busy", tgt, c),
                32'({bus.OUT, bus.DONE, bus.ABORTED, bus.BUSY}),
                32'({8'(eo), edone, 1'b0, ~edone}));
        end
        tick();
        chk($sformatf("seek%0d done pulse width", tgt),
            32'({bus.OUT, bus.DONE, bus.CMD_READY}), 32'({tgt, 1'b0, 1'b1}));
        exp_cnt = 32'(tgt);
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0);

        // Cycle table: inputs held across one edge, outputs checked just after it.
        tbl.push_back(v(1, 0,   5, 0, 0,  0, 0, 1, 1, 0, 0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 8'(i), 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  5, 1, 0, 1, 1, 0));
        tbl.push_back(v(1, 0,   2, 2, 0,  5, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 200, 0, 0,  5, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 200, 0, 0,  5, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 200, 0, 0,  4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  4, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  3, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  2, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  2, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 0,   2, 5, 0,  2, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  2, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 0,   9, 0, 0,  2, 0, 1, 1, 0, 0));
        for (int i = 3; i <= 9; i++)
            tbl.push_back(v(0, 0, 0, 0, 0, 8'(i), 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  9, 1, 0, 1, 1, 0));
        tbl.push_back(v(1, 1,  77, 0, 1,  9, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 1,  0, 1, 0, 0, 1, 0));
        tbl.push_back(v(1, 0,   1, 0, 0,  0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 0,  1, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0,   0, 0, 1,  1, 1, 0, 1, 1, 0));
        tbl.push_back(v(0, 0,   0, 0, 1,  1, 1, 0, 1, 0, 0));

        #7;
        chk("in-reset out/rdy/busy/dir/done/abt",
            32'({bus.OUT, bus.CMD_READY, bus.BUSY, bus.DIR, bus.DONE, bus.ABORTED}),
            32'({8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        tick();
        RESET = 1'b0;
        tick();
        chk("idle after reset",
            32'({bus.OUT, bus.CMD_READY, bus.BUSY, bus.DIR, bus.DONE, bus.ABORTED}),
            32'({8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));

        foreach (tbl[i]) begin
            drive(tbl[i].valid, tbl[i].clr, tbl[i].tgt, tbl[i].rate, tbl[i].abort);
            tick();
            chk($sformatf("vec%0d out/rdy/busy/dir/done/abt", i),
                32'({bus.OUT, bus.CMD_READY, bus.BUSY, bus.DIR, bus.DONE, bus.ABORTED}),
                32'({tbl[i].e_out, tbl[i].e_rdy, tbl[i].e_busy, tbl[i].e_dir,
                     tbl[i].e_done, tbl[i].e_abt}));
        end
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        exp_cnt = 1;

        seek(8'd250, 4'd0);
        seek(8'd255, 4'd0);
        seek(8'd0,   4'd0);

        // Abort mid-seek at OUT=17.
        drive(1'b1, 1'b0, 8'd200, 4'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        for (int c = 1; c <= 17; c++) tick();
        chk("abort-seq out before abort", 32'({bus.OUT, bus.BUSY}), 32'({8'd17, 1'b1}));
        bus.ABORT = 1'b1;
        tick();
        chk("abort edge out/abt/done/busy/rdy",
            32'({bus.OUT, bus.ABORTED, bus.DONE, bus.BUSY, bus.CMD_READY}),
            32'({8'd17, 1'b1, 1'b0, 1'b0, 1'b1}));
        bus.ABORT = 1'b0;
        tick();
        chk("after abort out/abt/done",
            32'({bus.OUT, bus.ABORTED, bus.DONE}), 32'({8'd17, 1'b0, 1'b0}));
        exp_cnt = 17;

        seek(8'd20, 4'd3);

        // Async reset mid-seek: outputs return to reset values before the next edge.
        drive(1'b1, 1'b0, 8'd100, 4'd1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 8'd0, 4'd0, 1'b0);
        for (int c = 1; c <= 4; c++) tick();
        chk("pre-reset out", 32'({bus.OUT, bus.BUSY}), 32'({8'd22, 1'b1}));
        #3;
        RESET = 1'b1;
        #1;
        chk("async reset out/rdy/busy/dir/done/abt",
            32'({bus.OUT, bus.CMD_READY, bus.BUSY, bus.DIR, bus.DONE, bus.ABORTED}),
            32'({8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        tick();
        RESET = 1'b0;
        tick();
        chk("post-reset no done",
            32'({bus.OUT, bus.CMD_READY, bus.BUSY, bus.DONE, bus.ABORTED}),
            32'({8'd0, 1'b1, 1'b0, 1'b0, 1'b0}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_seek_ctrl.md
Name: counter_seek_ctrl

Overview:
- Command-driven sequencer that owns an 8-bit up/down counter and steps it toward a requested target value, one count per step, at a programmable rate.
- Sits between a host-side command source (valid/ready handshake) and any logic that consumes the counter value OUT.
- Adds what the bare counter lacks: hold, seek-to-target, clear, abort and completion signalling.

Parameters:
- WIDTH, 8, width of counter value and target.
- DIV_W, 4, width of the rate prescaler field (step every RATE+1 cycles).

Ports:
- CLOCK  input  1  single clock; all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_READY  output  1  controller can accept; combinational, high iff state==IDLE.
- CMD_CLEAR  input  1  command is clear-to-zero; overrides CMD_TARGET.
- CMD_TARGET  input  WIDTH  unsigned seek target.
- CMD_RATE  input  DIV_W  step interval minus one, sampled at accept.
- ABORT  input  1  stop an in-progress seek.
- OUT  output  WIDTH  current counter value.
- BUSY  output  1  high while in SEEK.
- DIR  output  1  1 = counting up, 0 = down/hold; registered at accept.
- DONE  output  1  one-cycle pulse: seek reached target or clear completed.
- ABORTED  output  1  one-cycle pulse: seek stopped by ABORT.

Behaviour:
- Reset (async, immediate, any state): state=IDLE, OUT=0, DIR=0, BUSY=0, DONE=0, ABORTED=0, prescaler=0, latched target/rate=0. CMD_READY=1 while in reset.
- States: IDLE, SEEK, CLEAR.
- Accept = CMD_VALID & CMD_READY at a rising edge (edge k). Latch target, rate, clear flag. Prescaler <= 0. DIR <= (CMD_TARGET > OUT) unsigned; DIR <= 0 for clear. Next state is CLEAR if CMD_CLEAR, else SEEK.
- CLEAR: at edge k+1, OUT <= 0, state <= IDLE, DONE <= 1.
- SEEK, evaluated each edge in this priority order:
  - (1) OUT == target: state <= IDLE, DONE <= 1, OUT unchanged.
  - (2) ABORT: state <= IDLE, ABORTED <= 1, OUT frozen.
  - (3) Prescaler == rate: OUT <= OUT ± 1 toward target, prescaler <= 0.
  - (4) Otherwise: prescaler <= prescaler + 1, OUT held.
- Latency, distance d = |target − OUT|, rate r: steps occur at edges k+(r+1), k+2(r+1), …, k+d(r+1). DONE is asserted in the cycle after edge k+d(r+1)+1. With d=0, DONE follows edge k+1.
- No wrap-around: OUT moves monotonically toward target and never passes through 0→255 or 255→0. Arithmetic is unsigned WIDTH bits, so no overflow is possible.
- DONE/ABORTED last exactly one cycle and are never high together. Equality at the same edge as ABORT yields DONE.
- BUSY = (state==SEEK). CLEAR counts as not-busy but CMD_READY is low during it.
- A new command may be accepted in the same cycle that DONE/ABORTED is high, since the state is already IDLE.
- ABORT outside SEEK is ignored; ABORT with an accepting command in IDLE does not block acceptance.
- CMD_TARGET/CMD_RATE changes after accept have no effect until the next accept.
- RESET asserted mid-seek clears everything immediately. No DONE/ABORTED pulse results.

Decomposition:
- Shared package counter_pkg: state encoding localparams (IDLE/SEEK/CLEAR), default WIDTH and DIV_W.
- One sub-module: updown_counter. Inputs CLOCK, RESET (async), EN, UP, CLR; output OUT. Holds when EN=0; CLR has priority over EN. The controller drives EN/UP/CLR from state and prescaler.

Test Plan:
- Reset then idle → OUT=0, CMD_READY=1, BUSY=0; pulse RESET mid-operation → all outputs back to reset values in the same cycle, no DONE.
- Seek 0→5, rate 0 → OUT 1,2,3,4,5 on consecutive edges, DIR=1, DONE single pulse one cycle after OUT=5, CMD_READY high with DONE.
- From OUT=5, seek 2, rate 2 → OUT decrements every 3 cycles (5,4,3,2), DIR=0, DONE after 10 cycles total.
- Seek to current value (OUT=2, target 2) → DONE one cycle after accept, OUT unchanged; seek 250→255 then 255→0 → monotonic, no wrap.
- Seek 0→200 rate 0, ABORT at OUT=17 → OUT holds 17, ABORTED one pulse, no DONE; ABORT on equality edge → DONE only.
- Clear while OUT=9 → OUT=0 at edge k+1, DONE pulse; back-to-back command in DONE cycle accepted; CMD_VALID held during SEEK not accepted (CMD_READY=0).
